// File: rtl/gate2_bist_pkg.sv
// Shared types, constants and pattern generators for the 2-input gate BIST.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate2_bist_pkg;

    typedef enum logic [2:0] {
        FUNC_NOR  = 3'd0,
        FUNC_NAND = 3'd1,
        FUNC_AND  = 3'd2,
        FUNC_OR   = 3'd3,
        FUNC_XOR  = 3'd4
    } func_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam int NUM_PAT_BASE = 4;
    localparam int NUM_PAT_CB   = 4;
    // Generators are this wide; callers truncate to their gate width (<= 64).
    localparam int PAT_MAX_W    = 64;

    function automatic logic [PAT_MAX_W-1:0] pattern_a();
        return {(PAT_MAX_W/2){2'b01}};
    endfunction

    function automatic logic [PAT_MAX_W-1:0] pattern_b();
        return ~pattern_a();
    endfunction

endpackage

// File: rtl/gate2_bist_if.sv
// Bundle between the BIST engine (master) and the gate vector / test controller.
// Latency: n/a (wires only).
// Backpressure: none; start is a level sampled by the engine when idle.
interface gate2_bist_if #(
    parameter int WIDTH = 1
);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] fail_mask;
    logic [3:0]       err_count;

    modport master (
        input  start, dut_out,
        output in1, in2, busy, done, pass, fail_mask, err_count
    );

    modport slave (
        output start, dut_out,
        input  in1, in2, busy, done, pass, fail_mask, err_count
    );
endinterface

// File: rtl/gate2_ref_model.sv
// Golden 2-input gate vector: exp = FUNC(in1, in2) bitwise.
// Latency: combinational.
// Backpressure: none.
module gate2_ref_model
    import gate2_bist_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int FUNC  = 0
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] exp
);
    localparam func_e F = func_e'(3'(FUNC));

    always_comb begin
        exp = '0;
        case (F)
            FUNC_NOR:  exp = ~(in1 | in2);
            FUNC_NAND: exp = ~(in1 & in2);
            FUNC_AND:  exp = in1 & in2;
            FUNC_OR:   exp = in1 | in2;
            FUNC_XOR:  exp = in1 ^ in2;
            default:   exp = '0;
        endcase
    end
endmodule

// File: rtl/gate2_bist.sv
// Exhaustive-pattern BIST for a 2-input gate vector; GATE2_BIST_CHECKERBOARD_EN adds 4 checkerboard patterns.
// Latency: (2+PAT_LAT) cycles per pattern, done one cycle after the last check.
// Backpressure: none; start is ignored while busy.
module gate2_bist
    import gate2_bist_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int FUNC    = 0,
    parameter int PAT_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    gate2_bist_if.master bus
);
`ifdef GATE2_BIST_CHECKERBOARD_EN
    localparam int NUM_PAT = NUM_PAT_BASE + NUM_PAT_CB;
    localparam int IDX_W   = 3;
    localparam logic [WIDTH-1:0] PAT_A = WIDTH'(pattern_a());
    localparam logic [WIDTH-1:0] PAT_B = WIDTH'(pattern_b());
`else
    localparam int NUM_PAT = NUM_PAT_BASE;
    localparam int IDX_W   = 2;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAT - 1);

    state_e           state;
    logic [IDX_W-1:0] idx;
    logic [3:0]       wait_cnt;
    logic [WIDTH-1:0] in1_q, in2_q, fail_mask_q;
    logic [3:0]       err_q;
    logic             busy_q, done_q, pass_q;
    logic [WIDTH-1:0] pat_in1, pat_in2, exp_w, mismatch;

    // Index bits select the pattern: bit0 -> in2 level, bit1 -> in1 level, bit2 -> checkerboard set.
    always_comb begin
        pat_in1 = idx[1] ? '1 : '0;
        pat_in2 = idx[0] ? '1 : '0;
`ifdef GATE2_BIST_CHECKERBOARD_EN
        if (idx[2]) begin
            pat_in1 = idx[1] ? PAT_B : PAT_A;
            pat_in2 = idx[0] ? PAT_B : PAT_A;
        end
`endif
    end

    gate2_ref_model #(.WIDTH(WIDTH), .FUNC(FUNC)) u_ref (
        .in1 (in1_q),
        .in2 (in2_q),
        .exp (exp_w)
    );

    assign mismatch = bus.dut_out ^ exp_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            fail_mask_q <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state       <= ST_DRIVE;
                        idx         <= '0;
                        fail_mask_q <= '0;
                        err_q       <= '0;
                        pass_q      <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    in1_q    <= pat_in1;
                    in2_q    <= pat_in2;
                    wait_cnt <= 4'(PAT_LAT);
                    state    <= (PAT_LAT > 0) ? ST_WAIT : ST_CHECK;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    fail_mask_q <= fail_mask_q | mismatch;
                    if ((|mismatch) && (err_q != 4'hF)) err_q <= err_q + 4'd1;
                    if (idx == LAST_IDX) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        pass_q <= ~|(fail_mask_q | mismatch);
                        in1_q  <= '0;
                        in2_q  <= '0;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_DRIVE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in1       = in1_q;
    assign bus.in2       = in2_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_gate2_bist.sv
// Bench for gate2_bist: cycle model on a 4-bit NOR instance plus directed runs on latency/swap/XOR instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_gate2_bist;

`ifdef GATE2_BIST_CHECKERBOARD_EN
    localparam int NPAT = 8;
`else
    localparam int NPAT = 4;
`endif
    localparam int RUN0 = NPAT * 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    gate2_bist_if #(.WIDTH(4)) b0 ();
    gate2_bist_if #(.WIDTH(4)) b1 ();
    gate2_bist_if #(.WIDTH(4)) b2 ();
    gate2_bist_if #(.WIDTH(2)) b3 ();
    gate2_bist_if #(.WIDTH(8)) b4 ();

    gate2_bist #(.WIDTH(4), .FUNC(0), .PAT_LAT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    gate2_bist #(.WIDTH(4), .FUNC(0), .PAT_LAT(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    gate2_bist #(.WIDTH(4), .FUNC(0), .PAT_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    gate2_bist #(.WIDTH(2), .FUNC(0), .PAT_LAT(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    gate2_bist #(.WIDTH(8), .FUNC(4), .PAT_LAT(0)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    // Gate vectors under test
    logic stuck = 1'b0;
    assign b0.dut_out = ~(b0.in1 | b0.in2) & (stuck ? 4'b1011 : 4'b1111);

    logic [3:0] d1a, d1b, d1c, d2a, d2b, d2c;
    always @(posedge clk) begin
        d1a <= ~(b1.in1 | b1.in2); d1b <= d1a; d1c <= d1b;
        d2a <= ~(b2.in1 | b2.in2); d2b <= d2a; d2c <= d2b;
    end
    assign b1.dut_out = d1c;
    assign b2.dut_out = d2c;
    assign b3.dut_out = {~(b3.in1[0] | b3.in2[0]), ~(b3.in1[1] | b3.in2[1])};
    assign b4.dut_out = ~(b4.in1 ^ b4.in2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    // Pattern p as seen on in1 / in2 (8 bits, truncated by narrower users)
    function automatic logic [7:0] pat_a(input int p);
        case (p)
            0, 1:    return 8'h00;
            2, 3:    return 8'hFF;
            4, 5:    return 8'h55;
            default: return 8'hAA;
        endcase
    endfunction

    function automatic logic [7:0] pat_b(input int p);
        case (p)
            0, 2:    return 8'h00;
            1, 3:    return 8'hFF;
            4, 6:    return 8'h55;
            default: return 8'hAA;
        endcase
    endfunction

    // Model of u0: mode 0 = reset values expected, mode 1 = run whose first DRIVE cycle is m_t0
    int   m_mode = 0;
    int   m_t0 = 0;
    logic m_stuck = 1'b0;

    initial begin : cmp
        logic [7:0] a8, b8;
        logic [3:0] e_in1, e_in2, e_mask, g, d;
        logic       e_busy, e_done, e_pass;
        int         e_err, t, p;
        forever begin
            @(negedge clk);
            e_in1 = '0; e_in2 = '0; e_mask = '0;
            e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0; e_err = 0;
            if (m_mode == 1) begin
                t = cyc - m_t0;
                e_busy = (t >= 0) && (t < RUN0);
                e_done = (t == RUN0);
                // During a DRIVE cycle the pins still carry the previous pattern
                if (e_busy && !(t < 3 && t % 3 == 0)) begin
                    p = (t % 3 == 0) ? t / 3 - 1 : t / 3;
                    a8 = pat_a(p); b8 = pat_b(p);
                    e_in1 = a8[3:0]; e_in2 = b8[3:0];
                end
                for (int q = 0; q < NPAT; q++) begin
                    if (q * 3 + 2 < t) begin
                        a8 = pat_a(q); b8 = pat_b(q);
                        g = ~(a8[3:0] | b8[3:0]);
                        d = m_stuck ? (g & 4'b1011) : g;
                        e_mask |= (g ^ d);
                        if ((g ^ d) != 4'b0) e_err++;
                    end
                end
                e_pass = (t >= RUN0) && (e_mask == 4'b0);
            end
            check("u0_in1", 32'(b0.in1), 32'(e_in1));
            check("u0_in2", 32'(b0.in2), 32'(e_in2));
            check("u0_busy", 32'(b0.busy), 32'(e_busy));
            check("u0_done", 32'(b0.done), 32'(e_done));
            check("u0_pass", 32'(b0.pass), 32'(e_pass));
            check("u0_fail_mask", 32'(b0.fail_mask), 32'(e_mask));
            check("u0_err_count", 32'(b0.err_count), 32'(e_err));
        end
    end

    task automatic run_start0();
        @(posedge clk); #1;
        b0.start = 1'b1;
        @(posedge clk); #1;
        b0.start = 1'b0;
        m_t0 = cyc;
        m_stuck = stuck;
        m_mode = 1;
    endtask

    task automatic wait_done0(output int dcyc, output int nbusy);
        dcyc = -1;
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b0.busy === 1'b1) nbusy++;
            if (b0.done === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
    endtask

    int dc, nb, t0g, ndone;
    int dn1, dn2, dn3, dn4;

    initial begin : stim
        b0.start = 1'b0; b1.start = 1'b0; b2.start = 1'b0; b3.start = 1'b0; b4.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_u4_fail_mask", 32'(b4.fail_mask), 32'h0);
        check("rst_u3_busy", 32'(b3.busy), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Clean run with a stray start in the 5th busy cycle
        run_start0();
        repeat (4) @(posedge clk);
        #1 b0.start = 1'b1;
        @(posedge clk); #1;
        b0.start = 1'b0;
        wait_done0(dc, nb);
        check("clean_run_len", 32'(dc - m_t0), 32'(RUN0));
        check("clean_pass", 32'(b0.pass), 32'h1);
        check("clean_mask", 32'(b0.fail_mask), 32'h0);
        check("clean_err", 32'(b0.err_count), 32'h0);

        // Bit 2 stuck-at-0, restarted straight from DONE
        stuck = 1'b1;
        run_start0();
        wait_done0(dc, nb);
        check("stuck_pass", 32'(b0.pass), 32'h0);
        check("stuck_mask", 32'(b0.fail_mask), 32'h4);
`ifdef GATE2_BIST_CHECKERBOARD_EN
        check("stuck_err", 32'(b0.err_count), 32'h2);
`else
        check("stuck_err", 32'(b0.err_count), 32'h1);
`endif
        stuck = 1'b0;

        // Latency, swap and XOR instances started together
        @(posedge clk); #1;
        b1.start = 1'b1; b2.start = 1'b1; b3.start = 1'b1; b4.start = 1'b1;
        @(posedge clk); #1;
        b1.start = 1'b0; b2.start = 1'b0; b3.start = 1'b0; b4.start = 1'b0;
        t0g = cyc;
        dn1 = -1; dn2 = -1; dn3 = -1; dn4 = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (b1.done === 1'b1 && dn1 < 0) dn1 = cyc - t0g;
            if (b2.done === 1'b1 && dn2 < 0) dn2 = cyc - t0g;
            if (b3.done === 1'b1 && dn3 < 0) dn3 = cyc - t0g;
            if (b4.done === 1'b1 && dn4 < 0) dn4 = cyc - t0g;
        end
        check("lat3_run_len", 32'(dn1), 32'(NPAT * 5));
        check("lat3_pass", 32'(b1.pass), 32'h1);
        check("lat3_mask", 32'(b1.fail_mask), 32'h0);
        check("lat2_run_len", 32'(dn2), 32'(NPAT * 4));
        check("lat2_pass", 32'(b2.pass), 32'h0);
        check("lat2_err_nonzero", 32'(b2.err_count != 4'd0), 32'h1);
        check("xor_run_len", 32'(dn4), 32'(NPAT * 2));
        check("xor_pass", 32'(b4.pass), 32'h0);
        check("xor_mask", 32'(b4.fail_mask), 32'hFF);
`ifdef GATE2_BIST_CHECKERBOARD_EN
        check("swap_run_len", 32'(dn3), 32'd24);
        check("swap_pass", 32'(b3.pass), 32'h0);
        check("swap_mask", 32'(b3.fail_mask), 32'h3);
        check("swap_err", 32'(b3.err_count), 32'h2);
        check("xor_err", 32'(b4.err_count), 32'h8);
`else
        check("swap_run_len", 32'(dn3), 32'd12);
        check("swap_pass", 32'(b3.pass), 32'h1);
        check("swap_mask", 32'(b3.fail_mask), 32'h0);
        check("swap_err", 32'(b3.err_count), 32'h0);
        check("xor_err", 32'(b4.err_count), 32'h4);
`endif

        // Reset during the WAIT cycle of pattern 2
        run_start0();
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        m_mode = 0;
        @(negedge clk);
        check("abort_busy", 32'(b0.busy), 32'h0);
        check("abort_in2", 32'(b0.in2), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b0.done === 1'b1) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'h0);

        // Recovery run after the abort
        run_start0();
        wait_done0(dc, nb);
        check("recover_busy_cycles", 32'(nb), 32'(RUN0));
        check("recover_pass", 32'(b0.pass), 32'h1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
